// File: rtl/popcount_pkg.sv
// Shared helpers and encodings for the pipelined popcount engine.
// Stage count and count width derive from the word width.
package popcount_pkg;

  localparam logic POP_MODE_WORD = 1'b0;
  localparam logic POP_MODE_ACC  = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int POP_STAGES(input int width);
    return clog2(width);
  endfunction

  function automatic int POP_CW(input int width);
    return clog2(width) + 1;
  endfunction

endpackage

// File: rtl/adder_nbit_cout.sv
// N-bit unsigned adder with carry out; the leaf cell of the popcount tree.
module adder_nbit_cout #(
  parameter int N = 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/popcount_tree_level.sv
// One adder-tree level: pairwise adds of GROUPS partial sums of IN_W bits,
// registered together with the valid/mode/last sideband under a shared enable.
module popcount_tree_level
  import popcount_pkg::*;
#(
  parameter int GROUPS = 2,
  parameter int IN_W   = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic                               in_valid,
  input  logic                               in_mode,
  input  logic                               in_last,
  input  logic [GROUPS*IN_W-1:0]             in_sums,
  output logic                               out_valid,
  output logic                               out_mode,
  output logic                               out_last,
  output logic [(GROUPS/2)*(IN_W+1)-1:0]     out_sums
);

  localparam int OUT_W = IN_W + 1;
  localparam int PAIRS = GROUPS / 2;

  logic [PAIRS*OUT_W-1:0] sum_w;
  logic [PAIRS*OUT_W-1:0] sums_d, sums_q;
  logic                   valid_d, valid_q;
  logic                   mode_d, mode_q;
  logic                   last_d, last_q;

  for (genvar g = 0; g < PAIRS; g++) begin : g_add
    adder_nbit_cout #(.N(IN_W)) u_add (
      .a    (in_sums[2*g*IN_W +: IN_W]),
      .b    (in_sums[(2*g+1)*IN_W +: IN_W]),
      .sum  (sum_w[g*OUT_W +: IN_W]),
      .cout (sum_w[g*OUT_W + IN_W])
    );
  end

  // Bubbles shift like beats, so the whole level moves or holds as one.
  always_comb begin
    sums_d  = sums_q;
    valid_d = valid_q;
    mode_d  = mode_q;
    last_d  = last_q;
    if (en) begin
      sums_d  = sum_w;
      valid_d = in_valid;
      mode_d  = in_mode;
      last_d  = in_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sums_q  <= '0;
      valid_q <= 1'b0;
      mode_q  <= POP_MODE_WORD;
      last_q  <= 1'b0;
    end else begin
      sums_q  <= sums_d;
      valid_q <= valid_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
    end
  end

  assign out_sums  = sums_q;
  assign out_valid = valid_q;
  assign out_mode  = mode_q;
  assign out_last  = last_q;

endmodule

// File: rtl/popcount_pipe.sv
// Streaming popcount: log2(WIDTH) registered adder-tree levels followed by an
// output/accumulator stage that either emits per-word counts or saturating frame sums.
module popcount_pipe
  import popcount_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_mode,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_count,
  output logic                 out_sat
);

  localparam int L  = POP_STAGES(WIDTH);
  localparam int CW = POP_CW(WIDTH);

  logic                 adv;
  logic                 out_valid_d, out_valid_q;
  logic [ACC_WIDTH-1:0] out_count_d, out_count_q;
  logic                 out_sat_d, out_sat_q;
  logic [ACC_WIDTH-1:0] acc_d, acc_q;
  logic                 sticky_d, sticky_q;

  // A single advance enable freezes every stage while a result waits.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    logic [(WIDTH>>k)*(k+1)-1:0] sums;
    logic                        v;
    logic                        m;
    logic                        l;
    if (k == 1) begin : g_src
      popcount_tree_level #(.GROUPS(WIDTH), .IN_W(1)) u_level (
        .clk       (clk),
        .rst       (rst),
        .en        (adv),
        .in_valid  (in_valid),
        .in_mode   (in_mode),
        .in_last   (in_last),
        .in_sums   (in_data),
        .out_valid (v),
        .out_mode  (m),
        .out_last  (l),
        .out_sums  (sums)
      );
    end else begin : g_src
      popcount_tree_level #(.GROUPS(WIDTH >> (k-1)), .IN_W(k)) u_level (
        .clk       (clk),
        .rst       (rst),
        .en        (adv),
        .in_valid  (g_lvl[k-1].v),
        .in_mode   (g_lvl[k-1].m),
        .in_last   (g_lvl[k-1].l),
        .in_sums   (g_lvl[k-1].sums),
        .out_valid (v),
        .out_mode  (m),
        .out_last  (l),
        .out_sums  (sums)
      );
    end
  end

  logic [CW-1:0]        fin_count;
  logic                 fin_valid;
  logic                 fin_mode;
  logic                 fin_last;
  logic [ACC_WIDTH-1:0] cnt_ext;
  logic [ACC_WIDTH:0]   acc_sum;
  logic [ACC_WIDTH-1:0] acc_clamped;
  logic                 acc_ovf;

  assign fin_count   = g_lvl[L].sums;
  assign fin_valid   = g_lvl[L].v;
  assign fin_mode    = g_lvl[L].m;
  assign fin_last    = g_lvl[L].l;
  assign cnt_ext     = ACC_WIDTH'(fin_count);
  assign acc_sum     = {1'b0, acc_q} + {1'b0, cnt_ext};
  assign acc_ovf     = acc_sum[ACC_WIDTH];
  assign acc_clamped = acc_ovf ? '1 : acc_sum[ACC_WIDTH-1:0];

  // Word beats bypass the accumulator; only a last frame beat emits and clears it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    if (adv) begin
      out_valid_d = 1'b0;
      if (fin_valid) begin
        if (fin_mode == POP_MODE_WORD) begin
          out_valid_d = 1'b1;
          out_count_d = cnt_ext;
          out_sat_d   = 1'b0;
        end else if (fin_last) begin
          out_valid_d = 1'b1;
          out_count_d = acc_clamped;
          out_sat_d   = sticky_q | acc_ovf;
          acc_d       = '0;
          sticky_d    = 1'b0;
        end else begin
          acc_d       = acc_clamped;
          sticky_d    = sticky_q | acc_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_popcount_pipe.sv
// Bench for popcount_pipe: two instances (16-bit and 8-bit accumulator) share one
// input stream; a frame-sum reference model feeds expected queues popped by a monitor.
module tb_popcount_pipe;

  localparam int W      = 16;
  localparam int L      = 4;
  localparam int P      = 10;
  localparam int LAT_NS = L * P + P / 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_mode;
  logic          in_last;
  logic          out_ready;
  logic          in_ready_a, in_ready_b;
  logic          out_valid_a, out_valid_b;
  logic [15:0]   out_count_a;
  logic [7:0]    out_count_b;
  logic          out_sat_a, out_sat_b;

  int            total;
  int            bad;
  logic          want_ready;
  logic          rand_bp;
  logic          check_lat;
  int            frame_sum;
  logic [16:0]   exp_a[$];
  logic [8:0]    exp_b[$];
  time           lat_q[$];
  logic          hold_a, hold_b;
  logic [16:0]   held_a;
  logic [8:0]    held_b;

  popcount_pipe #(.WIDTH(W), .ACC_WIDTH(16)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_count (out_count_a),
    .out_sat   (out_sat_a)
  );

  popcount_pipe #(.WIDTH(W), .ACC_WIDTH(8)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_count (out_count_b),
    .out_sat   (out_sat_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #(P/2) clk = ~clk;

  // out_ready moves shortly after each rising edge so it is stable at every sample point
  always @(posedge clk) begin
    #2;
    out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : want_ready;
  end

  // reference model
  function automatic int popcnt(input logic [W-1:0] d);
    int c;
    c = 0;
    for (int i = 0; i < W; i++) c += int'(d[i]);
    return c;
  endfunction

  task automatic model_accept(input logic [W-1:0] d, input logic m, input logic l);
    int c;
    c = popcnt(d);
    if (check_lat) lat_q.push_back($time);
    if (m == 1'b0) begin
      exp_a.push_back({1'b0, 16'(c)});
      exp_b.push_back({1'b0, 8'(c)});
    end else begin
      frame_sum += c;
      if (l) begin
        exp_a.push_back({frame_sum > 65535, (frame_sum > 65535) ? 16'hFFFF : 16'(frame_sum)});
        exp_b.push_back({frame_sum > 255, (frame_sum > 255) ? 8'hFF : 8'(frame_sum)});
        frame_sum = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // drivers
  task automatic send(input logic [W-1:0] d, input logic m, input logic l);
    logic ok;
    logic done;
    done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_last  = l;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      ok = in_ready_a;
      @(posedge clk);
      if (ok) begin
        done = 1'b1;
        model_accept(d, m, l);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout data=%h accepted=0 expected=1", d);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout left_a=%0d left_b=%0d expected=0", exp_a.size(), exp_b.size());
      exp_a.delete();
      exp_b.delete();
    end
    repeat (8) @(negedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      hold_a = 1'b0;
      hold_b = 1'b0;
    end else begin
      total += 2;
      if (in_ready_a !== (!out_valid_a || out_ready)) begin
        bad++;
        $display("FAIL in_ready_a actual=%b expected=%b", in_ready_a, !out_valid_a || out_ready);
      end
      if (in_ready_b !== (!out_valid_b || out_ready)) begin
        bad++;
        $display("FAIL in_ready_b actual=%b expected=%b", in_ready_b, !out_valid_b || out_ready);
      end
      if (hold_a) begin
        total++;
        if (out_valid_a !== 1'b1 || {out_sat_a, out_count_a} !== held_a) begin
          bad++;
          $display("FAIL stable_a actual=%b/%h expected=1/%h", out_valid_a, {out_sat_a, out_count_a}, held_a);
        end
      end
      if (hold_b) begin
        total++;
        if (out_valid_b !== 1'b1 || {out_sat_b, out_count_b} !== held_b) begin
          bad++;
          $display("FAIL stable_b actual=%b/%h expected=1/%h", out_valid_b, {out_sat_b, out_count_b}, held_b);
        end
      end
      if (out_valid_a && out_ready) begin
        total++;
        if (exp_a.size() == 0) begin
          bad++;
          $display("FAIL unexpected_a actual=sat%0d/%0d expected=none", out_sat_a, out_count_a);
        end else begin
          logic [16:0] e;
          e = exp_a.pop_front();
          if ({out_sat_a, out_count_a} !== e) begin
            bad++;
            $display("FAIL result_a actual=sat%0d/%0d expected=sat%0d/%0d", out_sat_a, out_count_a, e[16], e[15:0]);
          end
        end
        if (check_lat && lat_q.size() != 0) begin
          time t;
          t = lat_q.pop_front();
          total++;
          if ($time - t != LAT_NS) begin
            bad++;
            $display("FAIL latency actual=%0t expected=%0d", $time - t, LAT_NS);
          end
        end
      end
      if (out_valid_b && out_ready) begin
        total++;
        if (exp_b.size() == 0) begin
          bad++;
          $display("FAIL unexpected_b actual=sat%0d/%0d expected=none", out_sat_b, out_count_b);
        end else begin
          logic [8:0] e;
          e = exp_b.pop_front();
          if ({out_sat_b, out_count_b} !== e) begin
            bad++;
            $display("FAIL result_b actual=sat%0d/%0d expected=sat%0d/%0d", out_sat_b, out_count_b, e[8], e[7:0]);
          end
        end
      end
      hold_a = out_valid_a && !out_ready;
      held_a = {out_sat_a, out_count_a};
      hold_b = out_valid_b && !out_ready;
      held_b = {out_sat_b, out_count_b};
    end
  end

  // stimulus
  initial begin
    total      = 0;
    bad        = 0;
    frame_sum  = 0;
    rand_bp    = 1'b0;
    check_lat  = 1'b0;
    want_ready = 1'b1;
    out_ready  = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_mode    = 1'b0;
    in_last    = 1'b0;
    hold_a     = 1'b0;
    hold_b     = 1'b0;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_a", {15'd0, out_valid_a, out_sat_a, out_count_a}, 32'd0);
    chk("reset_out_b", {23'd0, out_valid_b, out_sat_b, out_count_b}, 32'd0);

    // back-to-back word results with the 5-cycle latency check
    check_lat = 1'b1;
    send(16'h0000, 1'b0, 1'b0);
    send(16'hFFFF, 1'b0, 1'b0);
    send(16'h8001, 1'b0, 1'b0);
    idle();
    drain();
    check_lat = 1'b0;
    lat_q.delete();

    // backpressure mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) send(16'($urandom_range(0, 16'hFFFF)), 1'b0, 1'b0);
        idle();
      end
      begin
        repeat (8) @(posedge clk);
        want_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", {31'd0, in_ready_a}, 32'd0);
        end
        @(posedge clk);
        want_ready = 1'b1;
      end
    join
    drain();

    // accumulate frame of 4 full words
    for (int i = 0; i < 4; i++) send(16'hFFFF, 1'b1, i == 3);
    idle();
    drain();

    // saturation on the 8-bit accumulator, then a fresh frame
    for (int i = 0; i < 17; i++) send(16'hFFFF, 1'b1, i == 16);
    send(16'h0003, 1'b1, 1'b1);
    idle();
    drain();

    // word beat interleaved inside an open frame
    send(16'h00FF, 1'b1, 1'b0);
    send(16'h0F0F, 1'b0, 1'b0);
    send(16'h0001, 1'b1, 1'b1);
    idle();
    drain();

    // asynchronous reset with a frame open and a result held
    want_ready = 1'b0;
    send(16'hFFFF, 1'b1, 1'b0);
    send(16'hFFFF, 1'b1, 1'b0);
    send(16'hFFFF, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 20 && !out_valid_a; i++) @(negedge clk);
    chk("held_before_reset", {31'd0, out_valid_a}, 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_a", {15'd0, out_valid_a, out_sat_a, out_count_a}, 32'd0);
    chk("async_reset_b", {23'd0, out_valid_b, out_sat_b, out_count_b}, 32'd0);
    exp_a.delete();
    exp_b.delete();
    frame_sum  = 0;
    want_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    send(16'h0001, 1'b1, 1'b1);
    idle();
    drain();

    // randomized mixed traffic with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 80; i++) begin
      logic m;
      m = ($urandom_range(0, 1) == 1);
      send(16'($urandom_range(0, 16'hFFFF)), m, m && ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) idle();
    end
    send(16'h0000, 1'b1, 1'b1);
    idle();
    rand_bp = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
